record_serializer: RTL and testbench

RECORD_SERIALIZER -- requirements
Module: record_serializer

---
 rtl/record_serializer.sv | 122 ++++++++++++
 tb/tb_record_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/record_serializer.sv
// Record serializer: reads one wide record from a non-show-ahead FIFO and
// presents it as a stream of bytes under a rdy/ack handshake, counting
// completed records.
module record_serializer #(
    parameter int N_BYTES   = 6,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sample_rdy,
    input  logic [8*N_BYTES-1:0]   sample,
    output logic                   sample_req,
    output logic                   data_rdy,
    output logic [7:0]             data,
    input  logic                   data_ack,
    output logic                   data_last,
    output logic [31:0]            records_sent
);

    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_LATCH,
        S_SEND
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [8*N_BYTES-1:0]   r_shift;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_sel;
    logic [31:0]            r_records;
    logic                   w_last;
    logic                   w_xfer;
    logic                   w_start;

    assign w_last       = (r_idx == LAST_IDX);
    assign w_xfer       = (r_state == S_SEND) && data_ack;
    assign w_start      = enable && sample_rdy;
    assign records_sent = r_records;

    // Byte-lane selection: the index counts transmitted bytes, the lane
    // order is flipped when the most significant byte goes first.
    assign w_sel = LSB_FIRST ? r_idx : (LAST_IDX - r_idx);

    // State register; reset discards any record in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; enable and sample_rdy are only
    // consulted in IDLE and on the final byte of a record.
    always_comb begin
        w_next     = r_state;
        sample_req = 1'b0;
        data_rdy   = 1'b0;
        data_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                sample_req = 1'b1;
                w_next     = S_LATCH;
            end
            S_LATCH: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                data_rdy  = 1'b1;
                data_last = w_last;
                if (data_ack && w_last) begin
                    w_next = w_start ? S_REQ : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Record capture, byte index and completed-record counter. The index
    // parks on the last byte after a record so data keeps its final value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_idx     <= '0;
            r_records <= '0;
        end else if (r_state == S_LATCH) begin
            r_shift <= sample;
            r_idx   <= '0;
        end else if (w_xfer) begin
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_records <= r_records + 32'd1;
            end
        end
    end

    // Output byte mux driven purely by stored state, so it is stable
    // between transfers and holds its value outside SEND.
    always_comb begin
        data = r_shift[7:0];
        for (int i = 0; i < N_BYTES; i++) begin
            if (w_sel == IDX_W'(i)) begin
                data = r_shift[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_record_serializer.sv
// Directed testbench for record_serializer: one LSB-first and one MSB-first
// instance share all inputs.
module tb_record_serializer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        sample_rdy;
    logic        data_ack;
    logic [47:0] sample;

    logic        sample_req0, data_rdy0, data_last0;
    logic [7:0]  data0;
    logic [31:0] rs0;
    logic        sample_req1, data_rdy1, data_last1;
    logic [7:0]  data1;
    logic [31:0] rs1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  exp_lsb [6] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hED, 8'hFE};
    logic [7:0]  exp_msb [6] = '{8'hFE, 8'hED, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [47:0] recs    [3] = '{48'h112233445566, 48'hA1B2C3D4E5F6, 48'h0123456789AB};
    logic [47:0] cur;

    record_serializer #(.N_BYTES(6), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .sample_rdy(sample_rdy),
        .sample(sample), .sample_req(sample_req0), .data_rdy(data_rdy0),
        .data(data0), .data_ack(data_ack), .data_last(data_last0),
        .records_sent(rs0)
    );

    record_serializer #(.N_BYTES(6), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .sample_rdy(sample_rdy),
        .sample(sample), .sample_req(sample_req1), .data_rdy(data_rdy1),
        .data(data1), .data_ack(data_ack), .data_last(data_last1),
        .records_sent(rs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        sample_rdy = 1'b0;
        data_ack   = 1'b0;
        sample     = '0;

        // Asynchronous reset, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_sample_req", {31'd0, sample_req0}, 32'd0);
        chk("rst_data_rdy",   {31'd0, data_rdy0},   32'd0);
        chk("rst_data",       {24'd0, data0},       32'd0);
        chk("rst_data_last",  {31'd0, data_last0},  32'd0);
        chk("rst_records",    rs0,                  32'd0);
        chk("rst_records1",   rs1,                  32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_no_req", {31'd0, sample_req0}, 32'd0);

        // Single record, ack held high
        sample     = 48'hFEEDDEADBEEF;
        enable     = 1'b1;
        sample_rdy = 1'b1;
        data_ack   = 1'b1;
        tick();
        chk("single_req",     {31'd0, sample_req0}, 32'd1);
        chk("single_req_rdy", {31'd0, data_rdy0},   32'd0);
        sample_rdy = 1'b0;
        tick();
        chk("single_latch_req", {31'd0, sample_req0}, 32'd0);
        chk("single_latch_rdy", {31'd0, data_rdy0},   32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("single_rdy",  {31'd0, data_rdy0},  32'd1);
            chk("single_data", {24'd0, data0},      {24'd0, exp_lsb[i]});
            chk("single_last", {31'd0, data_last0}, (i == 5) ? 32'd1 : 32'd0);
            chk("single_noreq", {31'd0, sample_req0}, 32'd0);
            tick();
        end
        chk("single_end_rdy",  {31'd0, data_rdy0},  32'd0);
        chk("single_end_last", {31'd0, data_last0}, 32'd0);
        chk("single_end_hold", {24'd0, data0},      32'h000000FE);
        chk("single_records",  rs0,                 32'd1);
        tick();
        chk("single_idle_req", {31'd0, sample_req0}, 32'd0);

        // Backpressure: five idle cycles before each acknowledged byte
        data_ack   = 1'b0;
        sample_rdy = 1'b1;
        tick();
        chk("bp_req", {31'd0, sample_req0}, 32'd1);
        sample_rdy = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 5; k++) begin
                chk("bp_hold_rdy",  {31'd0, data_rdy0},  32'd1);
                chk("bp_hold_data", {24'd0, data0},      {24'd0, exp_lsb[i]});
                chk("bp_hold_last", {31'd0, data_last0}, (i == 5) ? 32'd1 : 32'd0);
                tick();
            end
            data_ack = 1'b1;
            chk("bp_xfer_data", {24'd0, data0}, {24'd0, exp_lsb[i]});
            tick();
            data_ack = 1'b0;
        end
        chk("bp_end_rdy", {31'd0, data_rdy0}, 32'd0);
        chk("bp_records", rs0,                32'd2);

        // Back-to-back: three queued records, two-cycle gap between them
        data_ack   = 1'b1;
        sample_rdy = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            chk("b2b_req",     {31'd0, sample_req0}, 32'd1);
            chk("b2b_req_rdy", {31'd0, data_rdy0},   32'd0);
            sample = recs[r];
            tick();
            chk("b2b_latch_req", {31'd0, sample_req0}, 32'd0);
            chk("b2b_latch_rdy", {31'd0, data_rdy0},   32'd0);
            tick();
            cur = recs[r];
            for (int i = 0; i < 6; i++) begin
                chk("b2b_rdy",  {31'd0, data_rdy0},  32'd1);
                chk("b2b_data", {24'd0, data0},      {24'd0, cur[i*8 +: 8]});
                chk("b2b_last", {31'd0, data_last0}, (i == 5) ? 32'd1 : 32'd0);
                if (r == 2 && i == 5) sample_rdy = 1'b0;
                tick();
            end
        end
        chk("b2b_end_rdy", {31'd0, data_rdy0},   32'd0);
        chk("b2b_end_req", {31'd0, sample_req0}, 32'd0);
        chk("b2b_records", rs0,                  32'd5);
        tick();
        chk("b2b_idle_req", {31'd0, sample_req0}, 32'd0);

        // Enable dropped during the second byte with more records queued
        sample     = 48'h0A0B0C0D0E0F;
        sample_rdy = 1'b1;
        tick();
        chk("en_req", {31'd0, sample_req0}, 32'd1);
        tick();
        tick();
        cur = 48'h0A0B0C0D0E0F;
        for (int i = 0; i < 6; i++) begin
            chk("en_rdy",  {31'd0, data_rdy0},  32'd1);
            chk("en_data", {24'd0, data0},      {24'd0, cur[i*8 +: 8]});
            chk("en_last", {31'd0, data_last0}, (i == 5) ? 32'd1 : 32'd0);
            if (i == 1) enable = 1'b0;
            tick();
        end
        chk("en_records", rs0, 32'd6);
        for (int k = 0; k < 4; k++) begin
            chk("en_idle_req", {31'd0, sample_req0}, 32'd0);
            chk("en_idle_rdy", {31'd0, data_rdy0},   32'd0);
            tick();
        end

        // Asynchronous reset after three bytes of a record
        enable = 1'b1;
        sample = 48'h665544332211;
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ar_pre_data", {24'd0, data0}, {24'd0, 8'h11 + 8'(i * 8'h11)});
            tick();
        end
        chk("ar_byte3", {24'd0, data0}, 32'h00000044);
        #2 reset = 1'b1;
        #1;
        chk("ar_rdy",     {31'd0, data_rdy0},   32'd0);
        chk("ar_records", rs0,                  32'd0);
        chk("ar_data",    {24'd0, data0},       32'd0);
        chk("ar_req",     {31'd0, sample_req0}, 32'd0);
        chk("ar_last",    {31'd0, data_last0},  32'd0);
        sample = 48'hCAFE00BEEF77;
        tick();
        chk("ar_hold_rdy", {31'd0, data_rdy0}, 32'd0);
        reset = 1'b0;
        tick();
        chk("ar_fresh_req", {31'd0, sample_req0}, 32'd1);
        tick();
        tick();
        cur = 48'hCAFE00BEEF77;
        for (int i = 0; i < 6; i++) begin
            chk("ar_new_data", {24'd0, data0}, {24'd0, cur[i*8 +: 8]});
            if (i == 5) sample_rdy = 1'b0;
            tick();
        end
        chk("ar_new_records", rs0, 32'd1);

        // Counter wrap on the MSB-first instance
        force dut1.r_records = 32'hFFFFFFFE;
        tick();
        release dut1.r_records;
        tick();
        chk("wrap_preload", rs1, 32'hFFFFFFFE);
        sample     = 48'hFEEDDEADBEEF;
        sample_rdy = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            chk("wrap_req", {31'd0, sample_req1}, 32'd1);
            tick();
            tick();
            for (int i = 0; i < 6; i++) begin
                chk("wrap_rdy",  {31'd0, data_rdy1},  32'd1);
                chk("wrap_data", {24'd0, data1},      {24'd0, exp_msb[i]});
                chk("wrap_last", {31'd0, data_last1}, (i == 5) ? 32'd1 : 32'd0);
                if (r == 1 && i == 5) sample_rdy = 1'b0;
                tick();
            end
            chk("wrap_count", rs1, (r == 0) ? 32'hFFFFFFFF : 32'd0);
            chk("wrap_count0", rs0, 32'(2 + r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
